// File: rtl/cpu_controller_pkg.sv
// Shared definitions for the multicycle CPU controller: FSM state encoding,
// instruction classes, opcode/opExt constants and instruction-type codes.
package cpu_defs;

    typedef enum logic [2:0] {
        ST_FETCH      = 3'd0,
        ST_DECODE     = 3'd1,
        ST_EXEC       = 3'd2,
        ST_MEM        = 3'd3,
        ST_WB         = 3'd4,
        ST_PCINC_PREP = 3'd5,
        ST_PCINC      = 3'd6,
        ST_HALT       = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        CL_ALU  = 3'd0,
        CL_LOAD = 3'd1,
        CL_STOR = 3'd2,
        CL_NOP  = 3'd3,
        CL_HALT = 3'd4
    } instr_class_t;

    // Primary opcodes (IR[15:12])
    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_ANDI  = 4'b0001;
    localparam logic [3:0] OP_ORI   = 4'b0010;
    localparam logic [3:0] OP_XORI  = 4'b0011;
    localparam logic [3:0] OP_MEM   = 4'b0100;
    localparam logic [3:0] OP_CMPI  = 4'b1011;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    // Extended opcodes (IR[7:4])
    localparam logic [3:0] EXT_ADD  = 4'b0101;
    localparam logic [3:0] EXT_CMP  = 4'b1011;
    localparam logic [3:0] EXT_LOAD = 4'b0000;
    localparam logic [3:0] EXT_STOR = 4'b0100;

    // instrType codes presented to alu_control
    localparam logic ITYPE_R = 1'b0;
    localparam logic ITYPE_I = 1'b1;

endpackage

// File: rtl/cpu_controller_if.sv
// Memory handshake bundle between the controller (master) and memory (slave).
interface cpu_controller_if #(
    parameter int REG_WIDTH = 16
);
    logic                 memReady;
    logic [REG_WIDTH-1:0] memReadData;
    logic                 memReadReq;
    logic                 memWriteReq;
    logic                 memAddrSelect;

    modport master (
        input  memReady,
        input  memReadData,
        output memReadReq,
        output memWriteReq,
        output memAddrSelect
    );

    modport slave (
        output memReady,
        output memReadData,
        input  memReadReq,
        input  memWriteReq,
        input  memAddrSelect
    );
endinterface

// File: rtl/cpu_controller_instr_decoder.sv
// Combinational instruction decoder: classifies the instruction register and
// derives the ALU opcode, instruction type, extended immediate and write flags.
module instr_decoder
    import cpu_defs::*;
#(
    parameter int REG_WIDTH  = 16,
    parameter int INSTR_TYPE = 1
) (
    input  logic [REG_WIDTH-1:0]  ir_i,
    output instr_class_t          cls_o,
    output logic [3:0]            alu_op_o,
    output logic [INSTR_TYPE-1:0] instr_type_o,
    output logic [REG_WIDTH-1:0]  imm_ext_o,
    output logic                  is_cmp_o,
    output logic                  writes_reg_o
);

    logic [3:0] opcode;
    logic [3:0] op_ext;
    logic [7:0] imm8;

    assign opcode = ir_i[15:12];
    assign op_ext = ir_i[7:4];
    assign imm8   = ir_i[7:0];

    // Logical immediates are zero-extended, everything else sign-extended
    always_comb begin
        if (opcode == OP_ANDI || opcode == OP_ORI || opcode == OP_XORI) begin
            imm_ext_o = {{(REG_WIDTH-8){1'b0}}, imm8};
        end else begin
            imm_ext_o = {{(REG_WIDTH-8){imm8[7]}}, imm8};
        end
    end

    // Instruction class and ALU control; unrecognised encodings fall to NOP
    always_comb begin
        cls_o        = CL_NOP;
        alu_op_o     = 4'd0;
        instr_type_o = INSTR_TYPE'(ITYPE_R);
        is_cmp_o     = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                cls_o        = CL_ALU;
                alu_op_o     = op_ext;
                instr_type_o = INSTR_TYPE'(ITYPE_R);
                is_cmp_o     = (op_ext == EXT_CMP);
            end
            OP_MEM: begin
                if (op_ext == EXT_LOAD) begin
                    cls_o = CL_LOAD;
                end else if (op_ext == EXT_STOR) begin
                    cls_o = CL_STOR;
                end
            end
            OP_HALT: cls_o = CL_HALT;
            4'b1100, 4'b1101, 4'b1110: cls_o = CL_NOP;
            default: begin
                cls_o        = CL_ALU;
                alu_op_o     = opcode;
                instr_type_o = INSTR_TYPE'(ITYPE_I);
                is_cmp_o     = (opcode == OP_CMPI);
            end
        endcase
    end

    assign writes_reg_o = ((cls_o == CL_ALU) && !is_cmp_o) || (cls_o == CL_LOAD);

endmodule

// File: rtl/cpu_controller.sv
// Multicycle control FSM: fetches an instruction through the memory handshake,
// holds it in the IR, and sequences decode/execute/memory/write-back/PC-increment.
module cpu_controller
    import cpu_defs::*;
#(
    parameter int REG_WIDTH     = 16,
    parameter int REG_ADDR_BITS = 4,
    parameter int INSTR_TYPE    = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    cpu_controller_if.master         mem,
    output logic [REG_ADDR_BITS-1:0] regAddressA,
    output logic [REG_ADDR_BITS-1:0] regAddressB,
    output logic                     srcAddressRegEnable,
    output logic                     dstAddressRegEnable,
    output logic                     immediateRegEnable,
    output logic                     aluOutputRegEnable,
    output logic                     flagsEnable,
    output logic                     regWriteEnable,
    output logic                     pcEnable,
    output logic                     regWriteDataSelect,
    output logic                     aluInputAMuxSelect,
    output logic                     aluInputBMuxSelect,
    output logic [3:0]               aluOpCode,
    output logic [INSTR_TYPE-1:0]    instrType,
    output logic [REG_WIDTH-1:0]     immediate,
    output logic                     halted
);

    state_t               state_q, state_d;
    logic [REG_WIDTH-1:0] ir_q, ir_d;

    instr_class_t          dec_cls;
    logic [3:0]            dec_alu_op;
    logic [INSTR_TYPE-1:0] dec_type;
    logic [REG_WIDTH-1:0]  dec_imm;
    logic                  dec_is_cmp;
    logic                  dec_writes;

    instr_decoder #(
        .REG_WIDTH  (REG_WIDTH),
        .INSTR_TYPE (INSTR_TYPE)
    ) u_decoder (
        .ir_i         (ir_q),
        .cls_o        (dec_cls),
        .alu_op_o     (dec_alu_op),
        .instr_type_o (dec_type),
        .imm_ext_o    (dec_imm),
        .is_cmp_o     (dec_is_cmp),
        .writes_reg_o (dec_writes)
    );

    // Register fields come straight from the IR, so they only change on fetch
    assign regAddressA = REG_ADDR_BITS'(ir_q[3:0]);
    assign regAddressB = REG_ADDR_BITS'(ir_q[11:8]);

    // State and instruction register, asynchronously cleared
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_FETCH;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    // Next-state sequencing and IR capture on the fetch handshake
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        case (state_q)
            ST_FETCH: begin
                if (mem.memReady) begin
                    ir_d    = mem.memReadData;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                case (dec_cls)
                    CL_ALU:             state_d = ST_EXEC;
                    CL_LOAD, CL_STOR:   state_d = ST_MEM;
                    CL_HALT:            state_d = ST_HALT;
                    default:            state_d = ST_PCINC_PREP;
                endcase
            end
            ST_EXEC:       state_d = ST_WB;
            ST_MEM:        if (mem.memReady) state_d = ST_WB;
            ST_WB:         state_d = ST_PCINC;
            ST_PCINC_PREP: state_d = ST_PCINC;
            ST_PCINC:      state_d = ST_FETCH;
            ST_HALT:       state_d = ST_HALT;
            default:       state_d = ST_FETCH;
        endcase
    end

    // Moore control outputs; all forced inactive while reset is asserted
    always_comb begin
        mem.memReadReq      = 1'b0;
        mem.memWriteReq     = 1'b0;
        mem.memAddrSelect   = 1'b0;
        srcAddressRegEnable = 1'b0;
        dstAddressRegEnable = 1'b0;
        immediateRegEnable  = 1'b0;
        aluOutputRegEnable  = 1'b0;
        flagsEnable         = 1'b0;
        regWriteEnable      = 1'b0;
        pcEnable            = 1'b0;
        regWriteDataSelect  = 1'b0;
        aluInputAMuxSelect  = 1'b0;
        aluInputBMuxSelect  = 1'b0;
        aluOpCode           = 4'd0;
        instrType           = '0;
        immediate           = '0;
        halted              = 1'b0;
        if (reset) begin
            case (state_q)
                ST_FETCH: begin
                    mem.memReadReq = 1'b1;
                end
                ST_DECODE: begin
                    srcAddressRegEnable = 1'b1;
                    dstAddressRegEnable = 1'b1;
                    immediateRegEnable  = 1'b1;
                    aluOpCode           = dec_alu_op;
                    instrType           = dec_type;
                    aluInputBMuxSelect  = dec_type[0];
                    immediate           = dec_imm;
                end
                ST_EXEC: begin
                    aluOutputRegEnable = 1'b1;
                    flagsEnable        = 1'b1;
                    aluOpCode          = dec_alu_op;
                    instrType          = dec_type;
                    aluInputBMuxSelect = dec_type[0];
                    immediate          = dec_imm;
                end
                ST_MEM: begin
                    mem.memAddrSelect = 1'b1;
                    mem.memReadReq    = (dec_cls == CL_LOAD);
                    mem.memWriteReq   = (dec_cls == CL_STOR);
                    immediate         = dec_imm;
                end
                ST_WB: begin
                    regWriteEnable     = dec_writes;
                    regWriteDataSelect = (dec_cls == CL_LOAD);
                    immediate          = REG_WIDTH'(1);
                    immediateRegEnable = 1'b1;
                end
                ST_PCINC_PREP: begin
                    immediate          = REG_WIDTH'(1);
                    immediateRegEnable = 1'b1;
                end
                ST_PCINC: begin
                    aluInputAMuxSelect = 1'b1;
                    aluInputBMuxSelect = 1'b1;
                    aluOpCode          = EXT_ADD;
                    instrType          = INSTR_TYPE'(ITYPE_R);
                    immediate          = REG_WIDTH'(1);
                    pcEnable           = 1'b1;
                end
                ST_HALT: begin
                    halted = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_controller.sv
// Self-checking bench for cpu_controller: acts as the instruction/data memory
// and compares per-instruction behaviour against a reference model.
module tb_cpu_controller;

    logic        clk;
    logic        reset;
    logic [3:0]  regAddressA, regAddressB;
    logic        srcAddressRegEnable, dstAddressRegEnable, immediateRegEnable;
    logic        aluOutputRegEnable, flagsEnable, regWriteEnable, pcEnable;
    logic        regWriteDataSelect, aluInputAMuxSelect, aluInputBMuxSelect;
    logic [3:0]  aluOpCode;
    logic [0:0]  instrType;
    logic [15:0] immediate;
    logic        halted;

    int checks   = 0;
    int failures = 0;

    cpu_controller_if #(.REG_WIDTH(16)) mif ();

    cpu_controller #(
        .REG_WIDTH     (16),
        .REG_ADDR_BITS (4),
        .INSTR_TYPE    (1)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .mem                 (mif.master),
        .regAddressA         (regAddressA),
        .regAddressB         (regAddressB),
        .srcAddressRegEnable (srcAddressRegEnable),
        .dstAddressRegEnable (dstAddressRegEnable),
        .immediateRegEnable  (immediateRegEnable),
        .aluOutputRegEnable  (aluOutputRegEnable),
        .flagsEnable         (flagsEnable),
        .regWriteEnable      (regWriteEnable),
        .pcEnable            (pcEnable),
        .regWriteDataSelect  (regWriteDataSelect),
        .aluInputAMuxSelect  (aluInputAMuxSelect),
        .aluInputBMuxSelect  (aluInputBMuxSelect),
        .aluOpCode           (aluOpCode),
        .instrType           (instrType),
        .immediate           (immediate),
        .halted              (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] all_outputs();
        return {mif.memReadReq, mif.memWriteReq, mif.memAddrSelect,
                srcAddressRegEnable, dstAddressRegEnable, immediateRegEnable,
                aluOutputRegEnable, flagsEnable, regWriteEnable, pcEnable,
                regWriteDataSelect, aluInputAMuxSelect, aluInputBMuxSelect,
                halted, instrType, 1'b0};
    endfunction

    // Run one instruction from its fetch cycle through PC increment (or HALT).
    // wf / wm: memReady wait cycles inserted in fetch / memory phases.
    task automatic run_instr(input logic [15:0] instr, input int wf, input int wm);
        int   cyc = 0, nfetch = 0, nmrd = 0, nmwr = 0, nwb = 0, nfl = 0, npc = 0;
        int   wf_left = wf, wm_left = wm;
        bit   done = 0, saw_halt = 0;
        logic [3:0]  dA = 0, dB = 0, eOp = 0, wB = 0, pOp = 0;
        logic [15:0] dImm = 0;
        logic        eTy = 0, eBm = 0, wSel = 0, pA = 0, pBm = 0, pTy = 0;
        logic [3:0]  op, ext;
        bit   is_halt, is_ld, is_st, is_alu, is_nop, is_cmp, is_itype;
        int   exp_cyc;
        logic [15:0] exp_imm;
        string t;

        // Reference model: instruction semantics from the ISA rules
        op       = instr[15:12];
        ext      = instr[7:4];
        is_halt  = (op == 4'hF);
        is_ld    = (op == 4'h4) && (ext == 4'h0);
        is_st    = (op == 4'h4) && (ext == 4'h4);
        is_alu   = (op == 4'h0) || ((op >= 4'h1) && (op <= 4'hB) && (op != 4'h4));
        is_nop   = !(is_halt || is_ld || is_st || is_alu);
        is_itype = is_alu && (op != 4'h0);
        is_cmp   = ((op == 4'h0) && (ext == 4'hB)) || (op == 4'hB);
        exp_imm  = ((op >= 4'h1) && (op <= 4'h3)) ? {8'h00, instr[7:0]}
                                                  : {{8{instr[7]}}, instr[7:0]};
        if (is_halt)           exp_cyc = 3 + wf;
        else if (is_nop)       exp_cyc = 4 + wf;
        else if (is_ld || is_st) exp_cyc = 5 + wf + wm;
        else                   exp_cyc = 5 + wf;

        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (mif.memReadReq && !mif.memAddrSelect) begin
                nfetch++;
                mif.memReadData = instr;
            end else begin
                mif.memReadData = 16'($urandom);
            end
            if (mif.memAddrSelect && mif.memReadReq)  nmrd++;
            if (mif.memAddrSelect && mif.memWriteReq) nmwr++;
            if (srcAddressRegEnable && dstAddressRegEnable && immediateRegEnable) begin
                dA = regAddressA; dB = regAddressB; dImm = immediate;
            end
            if (aluOutputRegEnable) begin
                eOp = aluOpCode; eTy = instrType[0]; eBm = aluInputBMuxSelect;
            end
            if (regWriteEnable) begin
                nwb++; wSel = regWriteDataSelect; wB = regAddressB;
            end
            if (flagsEnable) nfl++;
            if (pcEnable) begin
                npc++; pA = aluInputAMuxSelect; pBm = aluInputBMuxSelect;
                pOp = aluOpCode; pTy = instrType[0];
                done = 1;
            end
            if (halted) begin
                saw_halt = 1;
                done = 1;
            end
            if (mif.memReadReq || mif.memWriteReq) begin
                if (!mif.memAddrSelect) begin
                    if (wf_left > 0) begin mif.memReady = 1'b0; wf_left--; end
                    else mif.memReady = 1'b1;
                end else begin
                    if (wm_left > 0) begin mif.memReady = 1'b0; wm_left--; end
                    else mif.memReady = 1'b1;
                end
            end else begin
                mif.memReady = 1'($urandom_range(0, 1));
            end
        end

        t = $sformatf("%04h", instr);
        chk({t, " done"},      32'(done), 32'd1);
        chk({t, " cycles"},    cyc, exp_cyc);
        chk({t, " fetch"},     nfetch, 1 + wf);
        chk({t, " memrd"},     nmrd, is_ld ? 1 + wm : 0);
        chk({t, " memwr"},     nmwr, is_st ? 1 + wm : 0);
        chk({t, " regwr"},     nwb, ((is_alu && !is_cmp) || is_ld) ? 1 : 0);
        chk({t, " flags"},     nfl, is_alu ? 1 : 0);
        chk({t, " pcinc"},     npc, is_halt ? 0 : 1);
        chk({t, " halted"},    32'(saw_halt), 32'(is_halt));
        chk({t, " rsrc"},      32'(dA), 32'(instr[3:0]));
        chk({t, " rdest"},     32'(dB), 32'(instr[11:8]));
        chk({t, " imm"},       32'(dImm), 32'(exp_imm));
        if (is_alu) begin
            chk({t, " aluop"}, 32'(eOp), is_itype ? 32'(op) : 32'(ext));
            chk({t, " itype"}, 32'(eTy), 32'(is_itype));
            chk({t, " bmux"},  32'(eBm), 32'(is_itype));
        end
        if ((is_alu && !is_cmp) || is_ld) begin
            chk({t, " wbsel"}, 32'(wSel), 32'(is_ld));
            chk({t, " wbdst"}, 32'(wB), 32'(instr[11:8]));
        end
        if (!is_halt) begin
            chk({t, " pc_amux"},  32'(pA), 32'd1);
            chk({t, " pc_bmux"},  32'(pBm), 32'd1);
            chk({t, " pc_aluop"}, 32'(pOp), 32'h5);
            chk({t, " pc_itype"}, 32'(pTy), 32'd0);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        mif.memReady = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", 32'(all_outputs()), 32'd0);
        chk("reset_aluop",   32'(aluOpCode), 32'd0);
        chk("reset_imm",     32'(immediate), 32'd0);
        chk("reset_addr",    32'({regAddressA, regAddressB}), 32'd0);
        reset = 1'b1;
        #1;
        chk("post_reset_fetch", 32'({mif.memReadReq, mif.memAddrSelect}), 32'b10);
    endtask

    initial begin
        logic [15:0] directed [6];
        logic [15:0] r;
        int          bad;
        bit          hit;

        directed[0] = 16'h0152;
        directed[1] = 16'h53FF;
        directed[2] = 16'h13FF;
        directed[3] = 16'h4203;
        directed[4] = 16'hB152;
        directed[5] = 16'hC000;

        reset           = 1'b0;
        mif.memReady    = 1'b0;
        mif.memReadData = 16'h0000;
        apply_reset();

        for (int i = 0; i < 6; i++) begin
            run_instr(directed[i], 0, (i == 3) ? 3 : 0);
        end

        // Random mix of ALU, memory and undefined encodings with random waits
        for (int i = 0; i < 60; i++) begin
            r = 16'($urandom);
            case ($urandom_range(0, 3))
                0: r[15:12] = 4'h4;
                1: r[15:12] = 4'h0;
                default: ;
            endcase
            if (r[15:12] == 4'h4 && $urandom_range(0, 2) != 0)
                r[7:4] = ($urandom_range(0, 1) != 0) ? 4'h4 : 4'h0;
            if (r[15:12] == 4'hF) r[15:12] = 4'hC;
            run_instr(r, $urandom_range(0, 2), $urandom_range(0, 3));
        end

        // HALT: no further fetches until reset
        run_instr(16'hF000, 1, 0);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            mif.memReady = 1'($urandom_range(0, 1));
            if (mif.memReadReq || !halted) bad++;
        end
        chk("halt_hold", bad, 0);

        // Reset asserted in the middle of EXEC
        apply_reset();
        hit = 0;
        for (int i = 0; i < 10 && !hit; i++) begin
            @(negedge clk);
            mif.memReadData = 16'h0152;
            mif.memReady    = 1'b1;
            if (aluOutputRegEnable) hit = 1;
        end
        chk("reached_exec", 32'(hit), 32'd1);
        #1 reset = 1'b0;
        #1;
        chk("midexec_outputs", 32'(all_outputs()), 32'd0);
        chk("midexec_aluop",   32'(aluOpCode), 32'd0);
        chk("midexec_imm",     32'(immediate), 32'd0);
        mif.memReady = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midexec_refetch", 32'({mif.memReadReq, mif.memAddrSelect}), 32'b10);
        run_instr(16'h0152, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
